// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit 5-stage pipeline control path.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package cpu_pkg;

  // Opcodes (id_instr[15:12])
  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_SLTI  = 4'd3;
  localparam logic [3:0] OP_LW    = 4'd4;
  localparam logic [3:0] OP_SW    = 4'd5;
  localparam logic [3:0] OP_BEQ   = 4'd6;
  localparam logic [3:0] OP_HALT  = 4'd15;

  // Instruction field bit ranges
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RS_HI  = 11;
  localparam int RS_LO  = 9;
  localparam int RT_HI  = 8;
  localparam int RT_LO  = 6;
  localparam int RD_HI  = 5;
  localparam int RD_LO  = 3;

  // Sequencer state, kept as plain encoded constants
  typedef logic [1:0] ctrl_state_t;
  localparam ctrl_state_t ST_RUN    = 2'd0;
  localparam ctrl_state_t ST_DRAIN  = 2'd1;
  localparam ctrl_state_t ST_HALTED = 2'd2;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the stall/flush sequencer and the pipeline datapath.
// Latency: n/a (wires only).
// Backpressure: mem_wait from the datapath freezes the whole pipe.
interface pipeline_ctrl_if;
  logic [15:0] id_instr;
  logic        id_valid;
  logic        branch_taken;
  logic        mem_wait;
  logic        pc_en;
  logic        pc_sel_branch;
  logic        if_id_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_ma_en;
  logic        ma_wb_en;
  logic        halted;
  logic [15:0] stall_count;
  logic        timeout_err;

  // Controller side
  modport master (
    input  id_instr, id_valid, branch_taken, mem_wait,
    output pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_flush,
           ex_ma_en, ma_wb_en, halted, stall_count, timeout_err
  );

  // Datapath side
  modport slave (
    output id_instr, id_valid, branch_taken, mem_wait,
    input  pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_flush,
           ex_ma_en, ma_wb_en, halted, stall_count, timeout_err
  );
endinterface

// File: rtl/instr_src_decode.sv
// Source/destination register decode of the instruction sitting in ID.
// Latency: purely combinational.
// Backpressure: none.
module instr_src_decode
  import cpu_pkg::*;
(
  input  logic [15:0] instr_i,
  output logic        rs_used_o,
  output logic        rt_used_o,
  output logic [2:0]  rs_o,
  output logic [2:0]  rt_o,
  output logic        is_load_o,
  output logic [2:0]  dest_o,
  output logic        is_halt_o
);
  logic [3:0] opc;
  logic [2:0] rd;
  // funct bits belong to the ALU decode, not to hazard detection
  logic       unused_funct;

  assign opc          = instr_i[OPC_HI:OPC_LO];
  assign rs_o         = instr_i[RS_HI:RS_LO];
  assign rt_o         = instr_i[RT_HI:RT_LO];
  assign rd           = instr_i[RD_HI:RD_LO];
  assign unused_funct = ^instr_i[2:0];

  // Which register fields an opcode actually reads, and where it writes
  always_comb begin
    rs_used_o = 1'b0;
    rt_used_o = 1'b0;
    is_load_o = 1'b0;
    dest_o    = rt_o;
    is_halt_o = 1'b0;
    case (opc)
      OP_RTYPE: begin
        rs_used_o = 1'b1;
        rt_used_o = 1'b1;
        dest_o    = rd;
      end
      OP_ADDI, OP_SLTI: rt_used_o = 1'b1;
      OP_LW: begin
        rs_used_o = 1'b1;
        is_load_o = 1'b1;
      end
      OP_SW, OP_BEQ: begin
        rs_used_o = 1'b1;
        rt_used_o = 1'b1;
      end
      OP_HALT: is_halt_o = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: load-use stall, taken-beq squash, mem freeze, HALT drain.
// Latency: controls are combinational from state+inputs, acting at the next clk edge.
// Backpressure: mem_wait freezes every pipeline enable; DRAIN/HALTED stop fetch.
module pipeline_ctrl
  import cpu_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 64
) (
  input logic             clk,
  input logic             rst,
  pipeline_ctrl_if.master bus
);
  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES);
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

  logic        rs_used, rt_used, is_load, is_halt;
  logic [2:0]  rs, rt, dest;

  ctrl_state_t state_q, state_d;
  logic [2:0]  drain_cnt_q, drain_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        ex_load_q, ex_load_d;
  logic [2:0]  ex_dest_q, ex_dest_d;

  logic pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_flush;
  logic ex_ma_en, ma_wb_en;
  logic load_use, id_ex_adv;

  instr_src_decode u_dec (
    .instr_i   (bus.id_instr),
    .rs_used_o (rs_used),
    .rt_used_o (rt_used),
    .rs_o      (rs),
    .rt_o      (rt),
    .is_load_o (is_load),
    .dest_o    (dest),
    .is_halt_o (is_halt)
  );

  // A load in EX whose target is read by the real instruction in ID cannot be forwarded
  assign load_use = bus.id_valid && ex_load_q &&
                    ((rs_used && (rs == ex_dest_q)) || (rt_used && (rt == ex_dest_q)));

  // Control outputs and FSM next state, highest-priority condition first
  always_comb begin
    pc_en         = 1'b0;
    pc_sel_branch = 1'b0;
    if_id_en      = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_ma_en      = 1'b0;
    ma_wb_en      = 1'b0;
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.mem_wait) begin
            // full freeze; a pending branch stays held in EX by the datapath
          end else if (bus.branch_taken) begin
            pc_en         = 1'b1;
            pc_sel_branch = 1'b1;
            if_id_en      = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_ma_en      = 1'b1;
            ma_wb_en      = 1'b1;
          end else if (load_use) begin
            id_ex_flush = 1'b1;
            ex_ma_en    = 1'b1;
            ma_wb_en    = 1'b1;
          end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
            ex_ma_en = 1'b1;
            ma_wb_en = 1'b1;
            if (bus.id_valid && is_halt) begin
              state_d     = ST_DRAIN;
              drain_cnt_d = DRAIN_INIT;
            end
          end
        end
        ST_DRAIN: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          ex_ma_en    = !bus.mem_wait;
          ma_wb_en    = !bus.mem_wait;
          if (!bus.mem_wait) begin
            drain_cnt_d = drain_cnt_q - 3'd1;
            if (drain_cnt_d == 3'd0) state_d = ST_HALTED;
          end
        end
        default: ;
      endcase
    end
  end

  // ID/EX only moves in RUN when not frozen; a bubble wipes the load tracker
  assign id_ex_adv = (state_q == ST_RUN) && !bus.mem_wait && !id_ex_flush;

  // Next value of the EX load tracker
  always_comb begin
    ex_load_d = ex_load_q;
    ex_dest_d = ex_dest_q;
    if (id_ex_flush) begin
      ex_load_d = 1'b0;
      ex_dest_d = 3'd0;
    end else if (id_ex_adv) begin
      ex_load_d = bus.id_valid && is_load;
      ex_dest_d = dest;
    end
  end

  // Saturating stall counter, memory wait counter and sticky timeout flag
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (((state_q == ST_RUN) || (state_q == ST_DRAIN)) && !pc_en &&
        (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (!bus.mem_wait)
      wait_cnt_d = 8'd0;
    else if (wait_cnt_q != WAIT_LIMIT)
      wait_cnt_d = wait_cnt_q + 8'd1;
    else
      wait_cnt_d = wait_cnt_q;
    timeout_d = timeout_q || (wait_cnt_d == WAIT_LIMIT);
  end

  // State registers; reset aborts everything immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= 3'd0;
      wait_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
      ex_load_q   <= 1'b0;
      ex_dest_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      ex_load_q   <= ex_load_d;
      ex_dest_q   <= ex_dest_d;
    end
  end

  assign bus.pc_en         = pc_en;
  assign bus.pc_sel_branch = pc_sel_branch;
  assign bus.if_id_en      = if_id_en;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_flush   = id_ex_flush;
  assign bus.ex_ma_en      = ex_ma_en;
  assign bus.ma_wb_en      = ma_wb_en;
  assign bus.halted        = (state_q == ST_HALTED);
  assign bus.stall_count   = stall_cnt_q;
  assign bus.timeout_err   = timeout_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, directed corners, random vs model.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: mem_wait stimulus exercises freeze and timeout.
module tb_pipeline_ctrl;
  localparam int DRAIN_CYCLES = 3;
  localparam int MEM_TIMEOUT  = 64;

  // {pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_flush, ex_ma_en, ma_wb_en}
  localparam logic [6:0] C_RUN  = 7'b1010011;
  localparam logic [6:0] C_BR   = 7'b1111111;
  localparam logic [6:0] C_LU   = 7'b0000111;
  localparam logic [6:0] C_FRZ  = 7'b0000000;
  localparam logic [6:0] C_DRN  = 7'b0001111;
  localparam logic [6:0] C_DRNW = 7'b0001100;
  localparam logic [6:0] C_HLT  = 7'b0000000;
  localparam logic [6:0] C_RST  = 7'b0001100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  pipeline_ctrl_if bus();

  pipeline_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] ctl;
  assign ctl = {bus.pc_en, bus.pc_sel_branch, bus.if_id_en, bus.if_id_flush,
                bus.id_ex_flush, bus.ex_ma_en, bus.ma_wb_en};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One pipeline cycle: inputs applied after the edge, outputs valid at negedge
  task automatic drive(input logic [15:0] ins, input logic v, input logic b, input logic w);
    @(posedge clk);
    #1;
    bus.id_instr     = ins;
    bus.id_valid     = v;
    bus.branch_taken = b;
    bus.mem_wait     = w;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    bus.id_instr     = 16'h0000;
    bus.id_valid     = 1'b0;
    bus.branch_taken = 1'b0;
    bus.mem_wait     = 1'b0;
    #1;
    chk("rst_ctl", 32'(ctl), 32'(C_RST));
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_stall", 32'(bus.stall_count), 0);
    chk("rst_timeout", 32'(bus.timeout_err), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  int m_mode;   // 0 running, 1 draining, 2 halted
  int m_drain;  // drain cycles still owed
  int m_ex;     // register a load in EX will write, -1 if none
  int m_wait;
  int m_stall;
  bit m_to;

  task automatic m_reset();
    m_mode = 0; m_drain = 0; m_ex = -1; m_wait = 0; m_stall = 0; m_to = 0;
  endtask

  // Bitmask of registers read by an instruction
  function automatic logic [7:0] src_mask(input logic [15:0] ins);
    logic [7:0] m;
    m = 8'h00;
    case (ins[15:12])
      4'd0, 4'd5, 4'd6: begin m[ins[11:9]] = 1'b1; m[ins[8:6]] = 1'b1; end
      4'd1, 4'd3:       m[ins[8:6]] = 1'b1;
      4'd4:             m[ins[11:9]] = 1'b1;
      default: ;
    endcase
    return m;
  endfunction

  function automatic bit m_hazard(input logic [15:0] ins, input logic v);
    logic [7:0] msk;
    msk = src_mask(ins);
    return v && (m_ex >= 0) && msk[m_ex];
  endfunction

  function automatic logic [6:0] m_expect(input logic [15:0] ins, input logic v,
                                         input logic b, input logic w);
    if (m_mode == 2) return C_HLT;
    if (m_mode == 1) return w ? C_DRNW : C_DRN;
    if (w) return C_FRZ;
    if (b) return C_BR;
    if (m_hazard(ins, v)) return C_LU;
    return C_RUN;
  endfunction

  task automatic m_step(input logic [15:0] ins, input logic v, input logic b, input logic w);
    logic [6:0] e;
    bit         haz;
    e   = m_expect(ins, v, b, w);
    haz = m_hazard(ins, v);
    if (m_mode != 2 && !e[6] && m_stall < 65535) m_stall = m_stall + 1;
    m_wait = w ? ((m_wait < MEM_TIMEOUT) ? m_wait + 1 : m_wait) : 0;
    if (m_wait == MEM_TIMEOUT) m_to = 1;
    if (m_mode == 0 && !w) begin
      if (b || haz) m_ex = -1;
      else begin
        if (v && ins[15:12] == 4'hF) begin m_mode = 1; m_drain = DRAIN_CYCLES; end
        m_ex = (v && ins[15:12] == 4'h4) ? int'(ins[8:6]) : -1;
      end
    end else if (m_mode == 1) begin
      m_ex = -1;
      if (!w) begin
        m_drain = m_drain - 1;
        if (m_drain == 0) m_mode = 2;
      end
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] op;
    case ($urandom % 9)
      0: op = 4'd0;
      1: op = 4'd1;
      2: op = 4'd3;
      3, 4: op = 4'd4;
      5: op = 4'd5;
      6: op = 4'd6;
      7: op = 4'd2;
      default: op = 4'd7;
    endcase
    if ($urandom % 30 == 0) op = 4'hF;
    return {op, 3'($urandom % 4), 3'($urandom % 4), 6'($urandom)};
  endfunction

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [15:0] instr;
    logic        vld;
    logic        br;
    logic        mw;
    logic [6:0]  ctl;
  } vec_t;

  vec_t tbl [23];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int         exp_stall;
    logic [15:0] ins;
    logic       v, b, w, w_last;
    logic [6:0] e;

    tbl[0]  = '{16'h4280, 1'b1, 1'b0, 1'b0, C_RUN}; // lw r2,0(r1)
    tbl[1]  = '{16'h0518, 1'b1, 1'b0, 1'b0, C_LU};  // add r3,r2,r4 -> stall
    tbl[2]  = '{16'h0518, 1'b1, 1'b0, 1'b0, C_RUN}; // single stall only
    tbl[3]  = '{16'h4280, 1'b1, 1'b0, 1'b0, C_RUN};
    tbl[4]  = '{16'h0718, 1'b1, 1'b0, 1'b0, C_RUN}; // independent
    tbl[5]  = '{16'h4280, 1'b1, 1'b0, 1'b0, C_RUN};
    tbl[6]  = '{16'h0518, 1'b1, 1'b1, 1'b0, C_BR};  // branch beats hazard
    tbl[7]  = '{16'h0518, 1'b1, 1'b0, 1'b0, C_RUN};
    tbl[8]  = '{16'h4280, 1'b1, 1'b0, 1'b1, C_FRZ};
    tbl[9]  = '{16'h4280, 1'b1, 1'b0, 1'b0, C_RUN};
    tbl[10] = '{16'h0518, 1'b0, 1'b0, 1'b0, C_RUN}; // bubble in ID
    tbl[11] = '{16'h4280, 1'b1, 1'b0, 1'b0, C_RUN};
    tbl[12] = '{16'h5280, 1'b1, 1'b0, 1'b0, C_LU};  // sw reads rt=r2
    tbl[13] = '{16'h5280, 1'b1, 1'b0, 1'b0, C_RUN};
    tbl[14] = '{16'h4280, 1'b1, 1'b0, 1'b0, C_RUN};
    tbl[15] = '{16'h1440, 1'b1, 1'b0, 1'b0, C_RUN}; // addi: rs not read
    tbl[16] = '{16'h4280, 1'b1, 1'b0, 1'b0, C_RUN};
    tbl[17] = '{16'h1280, 1'b1, 1'b0, 1'b0, C_LU};  // addi rt=r2
    tbl[18] = '{16'h1280, 1'b1, 1'b0, 1'b0, C_RUN};
    tbl[19] = '{16'h4280, 1'b1, 1'b0, 1'b0, C_RUN};
    tbl[20] = '{16'h0518, 1'b1, 1'b0, 1'b1, C_FRZ}; // hazard survives freeze
    tbl[21] = '{16'h0518, 1'b1, 1'b0, 1'b0, C_LU};
    tbl[22] = '{16'h0518, 1'b1, 1'b0, 1'b0, C_RUN};

    do_reset();
    exp_stall = 0;
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].instr, tbl[i].vld, tbl[i].br, tbl[i].mw);
      chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(tbl[i].ctl));
      chk($sformatf("vec%0d_stall", i), 32'(bus.stall_count), 32'(exp_stall));
      if (!tbl[i].ctl[6]) exp_stall++;
    end

    // Freeze with a pending branch: 5 frozen cycles then one squash
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(16'h0000, 1'b0, 1'b1, 1'b1);
      chk("frz_ctl", 32'(ctl), 32'(C_FRZ));
    end
    drive(16'h0000, 1'b0, 1'b1, 1'b0);
    chk("frz_branch_ctl", 32'(ctl), 32'(C_BR));
    chk("frz_stall", 32'(bus.stall_count), 5);
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    chk("frz_after_ctl", 32'(ctl), 32'(C_RUN));
    chk("frz_stall_after", 32'(bus.stall_count), 5);

    // Memory timeout
    do_reset();
    for (int i = 1; i <= MEM_TIMEOUT; i++) begin
      drive(16'h0000, 1'b0, 1'b0, 1'b1);
      chk($sformatf("to_pre%0d", i), 32'(bus.timeout_err), 0);
    end
    drive(16'h0000, 1'b0, 1'b0, 1'b1);
    chk("to_set", 32'(bus.timeout_err), 1);
    chk("to_still_frozen", 32'(ctl), 32'(C_FRZ));
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    chk("to_sticky", 32'(bus.timeout_err), 1);
    chk("to_run_ctl", 32'(ctl), 32'(C_RUN));
    chk("to_stall", 32'(bus.stall_count), MEM_TIMEOUT + 1);

    // Halt: three drain cycles, branch ignored while draining
    do_reset();
    drive(16'hF000, 1'b1, 1'b0, 1'b0);
    chk("halt_issue_ctl", 32'(ctl), 32'(C_RUN));
    for (int i = 0; i < DRAIN_CYCLES; i++) begin
      drive(16'h0518, 1'b1, (i == 1), 1'b0);
      chk("halt_drain_ctl", 32'(ctl), 32'(C_DRN));
      chk("halt_drain_halted", 32'(bus.halted), 0);
    end
    drive(16'h0000, 1'b1, 1'b0, 1'b0);
    chk("halt_halted", 32'(bus.halted), 1);
    chk("halt_ctl", 32'(ctl), 32'(C_HLT));
    chk("halt_stall", 32'(bus.stall_count), DRAIN_CYCLES);
    drive(16'h0000, 1'b1, 1'b1, 1'b0);
    chk("halt_stays_ctl", 32'(ctl), 32'(C_HLT));
    chk("halt_stays", 32'(bus.halted), 1);

    // Halt with two memory-wait cycles inside DRAIN
    do_reset();
    drive(16'hF000, 1'b1, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    chk("hw_d1", 32'(ctl), 32'(C_DRN));
    for (int i = 0; i < 2; i++) begin
      drive(16'h0000, 1'b0, 1'b0, 1'b1);
      chk("hw_wait_ctl", 32'(ctl), 32'(C_DRNW));
    end
    for (int i = 0; i < DRAIN_CYCLES - 1; i++) begin
      drive(16'h0000, 1'b0, 1'b0, 1'b0);
      chk("hw_drain_halted", 32'(bus.halted), 0);
    end
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    chk("hw_halted", 32'(bus.halted), 1);

    // Asynchronous reset in the middle of DRAIN
    do_reset();
    drive(16'hF000, 1'b1, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    drive(16'h0000, 1'b0, 1'b0, 1'b0);
    chk("rd_pre_stall", 32'(bus.stall_count), 1);
    chk("rd_pre_ctl", 32'(ctl), 32'(C_DRN));
    #2;
    rst = 1'b1;
    #1;
    chk("rd_ctl", 32'(ctl), 32'(C_RST));
    chk("rd_halted", 32'(bus.halted), 0);
    chk("rd_stall", 32'(bus.stall_count), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(16'h0000, 1'b1, 1'b0, 1'b0);
    chk("rd_run_ctl", 32'(ctl), 32'(C_RUN));

    // Randomized run against the reference model
    do_reset();
    m_reset();
    w_last = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      ins = rand_instr();
      v   = ($urandom % 5) != 0;
      b   = ($urandom % 7) == 0;
      w   = ($urandom % 100) < (w_last ? 70 : 15);
      w_last = w;
      drive(ins, v, b, w);
      e = m_expect(ins, v, b, w);
      chk("rnd_ctl", 32'(ctl), 32'(e));
      chk("rnd_halted", 32'(bus.halted), 32'(m_mode == 2));
      chk("rnd_stall", 32'(bus.stall_count), 32'(m_stall));
      chk("rnd_timeout", 32'(bus.timeout_err), 32'(m_to));
      m_step(ins, v, b, w);
      if ((m_mode == 2 && ($urandom % 4) == 0) || ($urandom % 600) == 0) begin
        do_reset();
        m_reset();
        w_last = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 16-bit 5-stage pipeline (IF, ID, EX, MA, WB). It detects load-use hazards that the forwarding logic cannot cover, and it squashes wrong-path instructions on a taken beq. It freezes the whole pipe while data RAM is busy and drains the pipe into a halted state on the HALT opcode. It drives the enable and flush controls of the PC and of every pipeline register.

Parameters:
DRAIN_CYCLES, 3, non-frozen cycles spent in DRAIN before HALTED (1..7).
MEM_TIMEOUT, 64, consecutive mem_wait cycles that set timeout_err (1..255).

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
id_instr  in  16  instruction currently in ID
id_valid  in  1  ID holds a real instruction (not a bubble)
branch_taken  in  1  beq in EX resolved taken this cycle
mem_wait  in  1  data RAM not ready; MA result not available this cycle
pc_en  out  1  PC register load enable
pc_sel_branch  out  1  PC loads branch target instead of PC+1
if_id_en  out  1  IF/ID register load enable
if_id_flush  out  1  IF/ID loads a bubble
id_ex_flush  out  1  ID/EX loads a bubble
ex_ma_en  out  1  EX/MA register load enable
ma_wb_en  out  1  MA/WB register load enable
halted  out  1  pipeline stopped after HALT
stall_count  out  16  saturating count of stalled cycles
timeout_err  out  1  sticky: mem_wait held for MEM_TIMEOUT cycles

Behaviour:
- Decode of id_instr: opcode [15:12], rs [11:9], rt [8:6], rd [5:3].
  - R-format op 0: reads rs, rt.
  - addi op 1 and slti op 3: read rt.
  - lw op 4: reads rs (base), writes rt.
  - sw op 5: reads rs and rt.
  - beq op 6: reads rs and rt.
  - HALT op 4'hF.
- Internal EX tracker: ex_load (1b), ex_dest (3b). Loaded from the ID decode whenever ID/EX advances. Cleared to 0 when id_ex_flush=1. Held while frozen.
- All control outputs are combinational from current state, tracker and inputs. They take effect at the next clk edge.
- FSM states: RUN, DRAIN, HALTED. Reset state is RUN.
- Reset (rst=1):
  - Outputs forced to: pc_en=0, pc_sel_branch=0, if_id_en=0, if_id_flush=1, id_ex_flush=1, ex_ma_en=0, ma_wb_en=0.
  - Registers cleared: halted=0, stall_count=0, timeout_err=0, tracker=0, wait counter=0, drain counter=0.
  - Reset asserted mid-operation aborts any state immediately.
- Priority in RUN, highest first:
  1. freeze: mem_wait=1. All enables 0, all flushes 0, pc_sel_branch=0. A pending branch_taken is deferred; the datapath holds it while EX is frozen.
  2. branch: branch_taken=1. pc_en=1, pc_sel_branch=1, if_id_flush=1, id_ex_flush=1, other enables 1. A HALT or load-use hazard in ID that cycle is discarded.
  3. load-use: id_valid=1, ex_load=1 and ex_dest equals a source register of the ID instruction. pc_en=0, if_id_en=0, id_ex_flush=1, ex_ma_en=ma_wb_en=1. The stall lasts exactly one cycle, because the bubble clears ex_load.
  4. halt: id_valid=1 and opcode=4'hF. The HALT itself advances normally. Next state is DRAIN with drain counter=DRAIN_CYCLES.
  5. otherwise: all enables 1, all flushes 0.
- DRAIN:
  - Outputs: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1; ex_ma_en and ma_wb_en follow !mem_wait.
  - branch_taken is ignored.
  - The drain counter decrements on cycles with mem_wait=0. When it reaches 0 → HALTED.
- HALTED:
  - Outputs: all enables 0, flushes 0, halted=1.
  - Left only by reset.
- stall_count: increments by 1 on every cycle in RUN or DRAIN with pc_en=0. Saturates at 16'hFFFF; does not wrap.
- Wait counter (8b):
  - Increments each cycle mem_wait=1 and clears when mem_wait=0.
  - When it reaches MEM_TIMEOUT, timeout_err is set and stays set until reset.
  - Freeze continues regardless of timeout_err.
  - The counter saturates at MEM_TIMEOUT.

Decomposition:
- Shared package `cpu_pkg`:
  - opcode constants: OP_RTYPE=0, OP_ADDI=1, OP_SLTI=3, OP_LW=4, OP_SW=5, OP_BEQ=6, OP_HALT=15.
  - instruction field bit ranges.
  - ctrl state typedef.
- One sub-module, `instr_src_decode`: purely combinational. Takes id_instr and outputs rs_used, rt_used, is_load, dest, is_halt. It is reusable by the forwarding unit.

Test Plan:
- Load-use: 16'h4280 (lw r2,0(r1)) into ID, then 16'h0518 (add r3,r2,r4). Required: exactly one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_count=1. Independent 16'h0718 after the lw → no stall.
- Branch vs hazard: branch_taken=1 in the same cycle as a load-use pair in ID. Required: pc_sel_branch=1, both flushes=1, pc_en=1; no stall cycle; stall_count unchanged.
- Mem freeze: mem_wait=1 for 5 cycles with branch_taken=1. Required: all enables 0 for 5 cycles, stall_count=5; on cycle 6 the branch flush is issued once.
- Timeout: mem_wait=1 for 64 cycles. Required: timeout_err rises on cycle 64 and stays 1 after mem_wait drops.
- Halt: 16'hF000 in ID. Required: DRAIN for 3 cycles, then halted=1 with all enables 0. With mem_wait=1 for 2 cycles during DRAIN, halted rises 2 cycles later.
- Reset mid-DRAIN: rst=1 asynchronously. Required: outputs immediately show reset values, halted=0, stall_count=0; after release, state is RUN.
